// File: rtl/toaplan2_cen_meter.sv
// Measures the rate of one CEN strobe over a fixed CLK96 window and flags range and CEN/CENB overlap errors.
// Define TOAPLAN2_CEN_METER_JITTER_EN to also publish the min/max interval between CEN pulses.
module toaplan2_cen_meter #(
  parameter int WINDOW  = 96000,
  parameter int CW      = 16,
  parameter int EXP_MIN = 3990,
  parameter int EXP_MAX = 4010,
  parameter int GW      = 12
) (
  input  logic          CLK96,
  input  logic          RESET_N,
  input  logic          ENABLE,
  input  logic          CEN,
  input  logic          CENB,
  output logic [CW-1:0] COUNT,
  output logic          VALID,
  output logic          TOO_LOW,
  output logic          TOO_HIGH,
  output logic          OVERLAP,
  output logic          BUSY,
  output logic [GW-1:0] MIN_GAP,
  output logic [GW-1:0] MAX_GAP
);

  localparam int              WINW = $clog2(WINDOW);
  localparam logic [WINW-1:0] LAST = WINW'(WINDOW - 1);
  localparam logic [CW-1:0]   PSAT = '1;
  localparam logic [31:0]     MINV = 32'(EXP_MIN);
  localparam logic [31:0]     MAXV = 32'(EXP_MAX);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_t;

  state_t          state_q, state_d;
  logic [WINW-1:0] win_q, win_d;
  logic [CW-1:0]   pulse_q, pulse_d;
  logic            ovl_q, ovl_d;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_q, valid_d;
  logic            low_q, low_d;
  logic            high_q, high_d;
  logic            ovlOut_q, ovlOut_d;

  logic [CW-1:0]   pulseInc;
  logic [31:0]     pulseWide;
  logic            startWin;
  logic            lastCyc;
  logic            clearAll;

  assign pulseInc  = (pulse_q == PSAT) ? pulse_q : pulse_q + CW'(1);
  assign pulseWide = 32'(pulse_d);
  assign startWin  = (state_q == ARM) && ENABLE && CEN;
  assign lastCyc   = (state_q == MEASURE) && ENABLE && (win_q == LAST);
  // An abort and the report cycle both drop the in-flight window state.
  assign clearAll  = (state_q == REPORT) ||
                     (((state_q == ARM) || (state_q == MEASURE)) && !ENABLE);

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    pulse_d  = pulse_q;
    ovl_d    = ovl_q;
    count_d  = count_q;
    valid_d  = 1'b0;
    low_d    = low_q;
    high_d   = high_q;
    ovlOut_d = ovlOut_q;
    unique case (state_q)
      IDLE: if (ENABLE) state_d = ARM;
      ARM: begin
        if (!ENABLE) begin
          state_d = IDLE;
        end else if (CEN) begin
          state_d = MEASURE;
          win_d   = WINW'(1);
          pulse_d = CW'(1);
          ovl_d   = CENB;
        end
      end
      MEASURE: begin
        if (!ENABLE) begin
          state_d = IDLE;
        end else begin
          if (CEN) pulse_d = pulseInc;
          ovl_d = ovl_q | (CEN & CENB);
          win_d = win_q + WINW'(1);
          // Results are latched on the last window cycle so they are visible during REPORT.
          if (win_q == LAST) begin
            state_d  = REPORT;
            count_d  = pulse_d;
            valid_d  = 1'b1;
            low_d    = pulseWide < MINV;
            high_d   = (pulse_d == PSAT) || (pulseWide > MAXV);
            ovlOut_d = ovl_d;
          end
        end
      end
      REPORT: state_d = ENABLE ? ARM : IDLE;
      default: state_d = IDLE;
    endcase
    if (clearAll) begin
      win_d   = '0;
      pulse_d = '0;
      ovl_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK96 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      win_q    <= '0;
      pulse_q  <= '0;
      ovl_q    <= 1'b0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      low_q    <= 1'b0;
      high_q   <= 1'b0;
      ovlOut_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      pulse_q  <= pulse_d;
      ovl_q    <= ovl_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      low_q    <= low_d;
      high_q   <= high_d;
      ovlOut_q <= ovlOut_d;
    end
  end

  assign COUNT    = count_q;
  assign VALID    = valid_q;
  assign TOO_LOW  = low_q;
  assign TOO_HIGH = high_q;
  assign OVERLAP  = ovlOut_q;
  assign BUSY     = (state_q == ARM) || (state_q == MEASURE);

`ifdef TOAPLAN2_CEN_METER_JITTER_EN
  localparam logic [GW-1:0] GSAT = '1;

  logic [GW-1:0] gap_q, gap_d;
  logic [GW-1:0] minG_q, minG_d;
  logic [GW-1:0] maxG_q, maxG_d;
  logic          seen_q, seen_d;
  logic [GW-1:0] minOut_q, minOut_d;
  logic [GW-1:0] maxOut_q, maxOut_d;
  logic [GW-1:0] gapInc;

  assign gapInc = (gap_q == GSAT) ? gap_q : gap_q + GW'(1);

  // seen_q marks that at least one interval exists, so a 0/1-pulse window publishes zeros.
  always_comb begin
    gap_d    = gap_q;
    minG_d   = minG_q;
    maxG_d   = maxG_q;
    seen_d   = seen_q;
    minOut_d = minOut_q;
    maxOut_d = maxOut_q;
    if (clearAll) begin
      gap_d  = '0;
      minG_d = '0;
      maxG_d = '0;
      seen_d = 1'b0;
    end else if (startWin) begin
      gap_d  = GW'(1);
      minG_d = '0;
      maxG_d = '0;
      seen_d = 1'b0;
    end else if (state_q == MEASURE) begin
      if (CEN) begin
        gap_d  = GW'(1);
        seen_d = 1'b1;
        minG_d = (!seen_q || (gap_q < minG_q)) ? gap_q : minG_q;
        maxG_d = (!seen_q || (gap_q > maxG_q)) ? gap_q : maxG_q;
      end else begin
        gap_d = gapInc;
      end
      if (lastCyc) begin
        minOut_d = seen_d ? minG_d : '0;
        maxOut_d = seen_d ? maxG_d : '0;
      end
    end
  end

  always_ff @(posedge CLK96 or negedge RESET_N) begin
    if (!RESET_N) begin
      gap_q    <= '0;
      minG_q   <= '0;
      maxG_q   <= '0;
      seen_q   <= 1'b0;
      minOut_q <= '0;
      maxOut_q <= '0;
    end else begin
      gap_q    <= gap_d;
      minG_q   <= minG_d;
      maxG_q   <= maxG_d;
      seen_q   <= seen_d;
      minOut_q <= minOut_d;
      maxOut_q <= maxOut_d;
    end
  end

  assign MIN_GAP = minOut_q;
  assign MAX_GAP = maxOut_q;
`else
  assign MIN_GAP = '0;
  assign MAX_GAP = '0;
`endif

endmodule

// File: tb/tb_toaplan2_cen_meter.sv
// Directed bench for toaplan2_cen_meter: two instances (240- and 290-cycle windows) checked every cycle
// against a window-level model, plus hand-computed literal expectations.
module tb_toaplan2_cen_meter;

  localparam int WA = 240, CWA = 4,  MINA = 9,  MAXA = 11;
  localparam int WB = 290, CWB = 16, MINB = 39, MAXB = 41;
  localparam int GWT = 12;
  localparam int HN = 16384;

  logic CLK96 = 1'b0;
  logic RESET_N = 1'b0;
  logic enA = 1'b0, enB = 1'b0;
  logic CEN = 1'b0, CENB = 1'b0;

  logic [CWA-1:0] countA;
  logic           validA, lowA, highA, ovlA, busyA;
  logic [GWT-1:0] minGapA, maxGapA;
  logic [CWB-1:0] countB;
  logic           validB, lowB, highB, ovlB, busyB;
  logic [GWT-1:0] minGapB, maxGapB;

  toaplan2_cen_meter #(.WINDOW(WA), .CW(CWA), .EXP_MIN(MINA), .EXP_MAX(MAXA), .GW(GWT)) dutA (
    .CLK96(CLK96), .RESET_N(RESET_N), .ENABLE(enA), .CEN(CEN), .CENB(CENB),
    .COUNT(countA), .VALID(validA), .TOO_LOW(lowA), .TOO_HIGH(highA), .OVERLAP(ovlA),
    .BUSY(busyA), .MIN_GAP(minGapA), .MAX_GAP(maxGapA));

  toaplan2_cen_meter #(.WINDOW(WB), .CW(CWB), .EXP_MIN(MINB), .EXP_MAX(MAXB), .GW(GWT)) dutB (
    .CLK96(CLK96), .RESET_N(RESET_N), .ENABLE(enB), .CEN(CEN), .CENB(CENB),
    .COUNT(countB), .VALID(validB), .TOO_LOW(lowB), .TOO_HIGH(highB), .OVERLAP(ovlB),
    .BUSY(busyB), .MIN_GAP(minGapB), .MAX_GAP(maxGapB));

  always #5 CLK96 = ~CLK96;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit histCen [0:HN-1];
  bit histCb  [0:HN-1];

  // Window-level view: where the current window began, whether a CEN may open one, and what was last published.
  typedef struct {
    int start;
    bit waiting;
    bit inRep;
    int count;
    bit valid, low, high, ovl, busy;
    int minG, maxG;
  } modelT;

  modelT mA, mB;

  function automatic modelT freshModel();
    modelT n;
    n.start = -1; n.waiting = 0; n.inRep = 0; n.count = 0;
    n.valid = 0; n.low = 0; n.high = 0; n.ovl = 0; n.busy = 0;
    n.minG = 0; n.maxG = 0;
    return n;
  endfunction

  // Results are computed from the recorded CEN/CENB history of the whole window once it completes.
  function automatic modelT step(modelT s, int k, bit en, int w, int cw, int emin, int emax);
    modelT n;
    int pulses, last, mn, mx, g, sat, capped;
    bit o;
    n = s;
    n.valid = 0;
    if (n.start >= 0) begin
      if (!en) begin
        n.start = -1;
      end else if (k - n.start == w - 1) begin
        pulses = 0; last = -1; mn = 0; mx = 0; o = 0;
        for (int i = n.start; i <= k; i++) begin
          if (histCen[i]) begin
            pulses++;
            if (histCb[i]) o = 1;
            if (last >= 0) begin
              g = i - last;
              if (g > (1 << GWT) - 1) g = (1 << GWT) - 1;
              if (mn == 0 || g < mn) mn = g;
              if (g > mx) mx = g;
            end
            last = i;
          end
        end
        sat = (1 << cw) - 1;
        capped = (pulses > sat) ? sat : pulses;
        n.count = capped;
        n.low   = capped < emin;
        n.high  = (capped > emax) || (capped == sat);
        n.ovl   = o;
        n.valid = 1;
`ifdef TOAPLAN2_CEN_METER_JITTER_EN
        n.minG = mn;
        n.maxG = mx;
`endif
        n.start = -1;
        n.inRep = 1;
      end
    end else if (n.inRep) begin
      n.inRep = 0;
      n.waiting = en;
    end else if (n.waiting) begin
      if (!en) n.waiting = 0;
      else if (histCen[k]) begin
        n.start = k;
        n.waiting = 0;
      end
    end else begin
      n.waiting = en;
    end
    n.busy = n.waiting || (n.start >= 0);
    return n;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model advances on every active edge with the inputs that edge sampled.
  always @(posedge CLK96) begin
    cyc++;
    if (cyc < HN) begin
      histCen[cyc] = CEN;
      histCb[cyc]  = CENB;
    end
    if (!RESET_N) begin
      mA = freshModel();
      mB = freshModel();
    end else begin
      mA = step(mA, cyc, enA, WA, CWA, MINA, MAXA);
      mB = step(mB, cyc, enB, WB, CWB, MINB, MAXB);
    end
  end

  // Every cycle, both instances are compared against the model just after the edge settles.
  always @(posedge CLK96) begin
    #1;
    checkOutput("A.COUNT", countA, mA.count);
    checkOutput("A.VALID", validA, mA.valid);
    checkOutput("A.TOO_LOW", lowA, mA.low);
    checkOutput("A.TOO_HIGH", highA, mA.high);
    checkOutput("A.OVERLAP", ovlA, mA.ovl);
    checkOutput("A.BUSY", busyA, mA.busy);
    checkOutput("A.MIN_GAP", minGapA, mA.minG);
    checkOutput("A.MAX_GAP", maxGapA, mA.maxG);
    checkOutput("B.COUNT", countB, mB.count);
    checkOutput("B.VALID", validB, mB.valid);
    checkOutput("B.TOO_LOW", lowB, mB.low);
    checkOutput("B.TOO_HIGH", highB, mB.high);
    checkOutput("B.OVERLAP", ovlB, mB.ovl);
    checkOutput("B.BUSY", busyB, mB.busy);
    checkOutput("B.MIN_GAP", minGapB, mB.minG);
    checkOutput("B.MAX_GAP", maxGapB, mB.maxG);
  end

  // CEN source: 0 silent, 1 periodic, 2 gaps 7,7,7,8, 3 held high.
  int mode = 0, period = 1, ph = 0, pi = 0;
  bit inject = 0;
  int pat [4] = '{7, 7, 7, 8};

  task automatic applyStimulus(input int m, input int p);
    mode = m; period = p; ph = 0; pi = 0;
  endtask

  task automatic tick();
    @(negedge CLK96);
    case (mode)
      1: begin
        CEN = (ph == 0);
        ph = (ph + 1 == period) ? 0 : ph + 1;
      end
      2: begin
        if (ph == 0) begin
          CEN = 1'b1;
          ph = pat[pi] - 1;
          pi = (pi + 1) % 4;
        end else begin
          CEN = 1'b0;
          ph--;
        end
      end
      3: CEN = 1'b1;
      default: CEN = 1'b0;
    endcase
    CENB = 1'b0;
    if (inject && CEN) begin
      CENB = 1'b1;
      inject = 0;
    end
  endtask

  task automatic waitValid(input int which, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      tick();
      if ((which == 0 && validA) || (which == 1 && validB)) return;
    end
    total++;
    bad++;
    $display("[TB] FAIL wait_valid(%0d): no VALID within %0d cycles, expected one", which, maxc);
  endtask

  task automatic checkGaps(input string tag, input int which, input int expMin, input int expMax);
`ifdef TOAPLAN2_CEN_METER_JITTER_EN
    checkOutput({tag, ".MIN_GAP"}, (which == 0) ? minGapA : minGapB, expMin);
    checkOutput({tag, ".MAX_GAP"}, (which == 0) ? maxGapA : maxGapB, expMax);
`else
    checkOutput({tag, ".MIN_GAP"}, (which == 0) ? minGapA : minGapB, 0);
    checkOutput({tag, ".MAX_GAP"}, (which == 0) ? maxGapA : maxGapB, 0);
`endif
  endtask

  initial begin
    int nv, c0, c1;
    repeat (3) tick();
    checkOutput("rst.A.COUNT", countA, 0);
    checkOutput("rst.A.BUSY", busyA, 0);
    checkOutput("rst.B.COUNT", countB, 0);
    RESET_N = 1'b1;

    $display("[TB] nominal rate");
    enA = 1'b1;
    applyStimulus(1, 24);
    waitValid(0, 600);
    checkOutput("nom.COUNT", countA, 10);
    checkOutput("nom.TOO_LOW", lowA, 0);
    checkOutput("nom.TOO_HIGH", highA, 0);
    checkOutput("nom.OVERLAP", ovlA, 0);
    checkGaps("nom", 0, 24, 24);
    waitValid(0, 600);
    checkOutput("nom2.COUNT", countA, 10);

    $display("[TB] low rate");
    applyStimulus(1, 48);
    waitValid(0, 600);
    waitValid(0, 600);
    checkOutput("low.COUNT", countA, 5);
    checkOutput("low.TOO_LOW", lowA, 1);
    checkOutput("low.TOO_HIGH", highA, 0);
    checkGaps("low", 0, 48, 48);

    $display("[TB] saturation");
    applyStimulus(3, 0);
    waitValid(0, 600);
    waitValid(0, 600);
    checkOutput("sat.COUNT", countA, 15);
    checkOutput("sat.TOO_HIGH", highA, 1);
    checkOutput("sat.TOO_LOW", lowA, 0);
    checkGaps("sat", 0, 1, 1);

    $display("[TB] abort");
    applyStimulus(1, 24);
    waitValid(0, 600);
    waitValid(0, 600);
    checkOutput("pre_abort.COUNT", countA, 10);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (CEN) break;
    end
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 100) enA = 1'b0;
    end
    tick();
    checkOutput("abort.BUSY", busyA, 0);
    checkOutput("abort.COUNT", countA, 10);
    checkOutput("abort.TOO_LOW", lowA, 0);
    nv = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (validA) nv++;
    end
    checkOutput("abort.no_valid", nv, 0);
    enA = 1'b1;
    tick();
    checkOutput("rearm.BUSY", busyA, 1);
    waitValid(0, 600);
    checkOutput("rearm.COUNT", countA, 10);
    enA = 1'b0;

    $display("[TB] overlap and fractional rate");
    enB = 1'b1;
    applyStimulus(2, 0);
    waitValid(1, 700);
    inject = 1;
    waitValid(1, 700);
    checkOutput("ovl.OVERLAP", ovlB, 1);
    checkOutput("ovl.COUNT", countB, 40);
    checkOutput("ovl.TOO_LOW", lowB, 0);
    checkOutput("ovl.TOO_HIGH", highB, 0);
    checkGaps("ovl", 1, 7, 8);
    waitValid(1, 700);
    checkOutput("clean.OVERLAP", ovlB, 0);
    checkOutput("clean.COUNT", countB, 40);
    enB = 1'b0;

    $display("[TB] reset mid-window");
    enA = 1'b1;
    applyStimulus(1, 24);
    repeat (80) tick();
    checkOutput("mid.BUSY", busyA, 1);
    RESET_N = 1'b0;
    applyStimulus(0, 0);
    #1;
    checkOutput("arst.A.COUNT", countA, 0);
    checkOutput("arst.A.BUSY", busyA, 0);
    checkOutput("arst.A.VALID", validA, 0);
    checkOutput("arst.B.COUNT", countB, 0);
    repeat (2) tick();
    RESET_N = 1'b1;
    repeat (5) tick();
    applyStimulus(1, 24);
    tick();
    c0 = cyc;
    waitValid(0, 600);
    c1 = cyc;
    checkOutput("post_rst.latency", c1 - c0 + 1, WA + 1);
    checkOutput("post_rst.COUNT", countA, 10);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule
